// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos memory arbiter slice.
package kronos_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INSTR,
    ARB_DATA
  } arb_state_t;

  localparam int unsigned ARB_STREAK_W = 4;

  // Encoding of the round-robin last-owner bit.
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/kronos_arb_policy.sv
// Combinational grant pick for kronos_mem_arb. KRONOS_MEM_ARB_RR_EN selects round-robin for the
// contested case; otherwise data wins until the fetch-starvation streak reaches its limit.
module kronos_arb_policy
  import kronos_types::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic                    instr_req,
  input  logic                    data_req,
  input  logic [ARB_STREAK_W-1:0] streak,
  input  logic                    last_owner,
  output logic                    grant_instr,
  output logic                    grant_data
);

  logic instr_wins;

`ifdef KRONOS_MEM_ARB_RR_EN
  logic unused_streak;
  assign unused_streak = ^streak;
  assign instr_wins    = (last_owner == OWNER_DATA);
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign instr_wins        = (streak == ARB_STREAK_W'(DATA_STREAK_MAX));
`endif

  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (instr_req && data_req) begin
      grant_instr = instr_wins;
      grant_data  = !instr_wins;
    end else begin
      grant_instr = instr_req;
      grant_data  = data_req;
    end
  end

endmodule

// File: rtl/kronos_mem_arb.sv
// Two-master arbiter sharing one registered memory bus between fetch and load/store.
// Define KRONOS_MEM_ARB_RR_EN for round-robin contention instead of data priority.
module kronos_mem_arb
  import kronos_types::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  arb_state_t              state_q, state_d;
  logic [ARB_STREAK_W-1:0] streak_q, streak_d;
  logic                    last_owner_q, last_owner_d;
  logic                    grant_instr, grant_data;
  logic                    take_instr, take_data;
  logic [31:0]             mem_addr_d, mem_wr_data_d;
  logic [3:0]              mem_mask_d;
  logic                    mem_wr_en_d, mem_req_d;

  kronos_arb_policy #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_policy (
    .instr_req  (instr_req),
    .data_req   (data_req),
    .streak     (streak_q),
    .last_owner (last_owner_q),
    .grant_instr(grant_instr),
    .grant_data (grant_data)
  );

  // Arbitration only happens in idle; master inputs are ignored while a transfer is open.
  assign take_instr = (state_q == ARB_IDLE) && grant_instr;
  assign take_data  = (state_q == ARB_IDLE) && grant_data;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_data) begin
          state_d = ARB_DATA;
        end else if (grant_instr) begin
          state_d = ARB_INSTR;
        end
      end
      ARB_INSTR, ARB_DATA: begin
        if (mem_ack) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    instr_ack = 1'b0;
    data_ack  = 1'b0;
    unique case (state_q)
      ARB_INSTR: instr_ack = mem_ack;
      ARB_DATA:  data_ack  = mem_ack;
      default: ;
    endcase
  end

  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

  always_comb begin
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    mem_mask_d    = mem_mask;
    mem_wr_en_d   = mem_wr_en;
    mem_req_d     = mem_req;
    if (take_data) begin
      mem_addr_d    = data_addr;
      mem_wr_data_d = data_wr_data;
      mem_mask_d    = data_mask;
      mem_wr_en_d   = data_wr_en;
      mem_req_d     = 1'b1;
    end else if (take_instr) begin
      mem_addr_d    = instr_addr;
      mem_wr_data_d = '0;
      mem_mask_d    = 4'hF;
      mem_wr_en_d   = 1'b0;
      mem_req_d     = 1'b1;
    end else if ((state_q != ARB_IDLE) && mem_ack) begin
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_mask    <= '0;
      mem_wr_en   <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      mem_addr    <= mem_addr_d;
      mem_wr_data <= mem_wr_data_d;
      mem_mask    <= mem_mask_d;
      mem_wr_en   <= mem_wr_en_d;
      mem_req     <= mem_req_d;
    end
  end

`ifdef KRONOS_MEM_ARB_RR_EN
  always_comb begin
    streak_d     = '0;
    last_owner_d = last_owner_q;
    if (take_instr) begin
      last_owner_d = OWNER_INSTR;
    end else if (take_data) begin
      last_owner_d = OWNER_DATA;
    end
  end
`else
  // Streak counts data grants that overtook a waiting fetch.
  always_comb begin
    last_owner_d = OWNER_INSTR;
    streak_d     = streak_q;
    if (take_instr) begin
      streak_d = '0;
    end else if (take_data) begin
      if (!instr_req) begin
        streak_d = '0;
      end else if (streak_q != '1) begin
        streak_d = streak_q + ARB_STREAK_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      streak_q     <= '0;
      last_owner_q <= OWNER_INSTR;
    end else begin
      streak_q     <= streak_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Self-checking bench for kronos_mem_arb: directed scenarios, then randomized traffic
// against a transaction-level reference model.
module tb_kronos_mem_arb;

  localparam int unsigned STREAK_MAX = 4;
  localparam int unsigned STREAK_SAT = 15;

  typedef enum int {OWN_NONE, OWN_I, OWN_D} own_t;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [31:0] instr_addr, data_addr, data_wr_data, mem_rd_data;
  logic [3:0]  data_mask;
  logic        data_wr_en, instr_req, data_req, mem_ack;
  logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en, mem_req, instr_ack, data_ack;

  kronos_mem_arb #(
    .DATA_STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk         (clk),
    .rstz        (rstz),
    .instr_addr  (instr_addr),
    .instr_req   (instr_req),
    .instr_data  (instr_data),
    .instr_ack   (instr_ack),
    .data_addr   (data_addr),
    .data_wr_data(data_wr_data),
    .data_mask   (data_mask),
    .data_wr_en  (data_wr_en),
    .data_req    (data_req),
    .data_rd_data(data_rd_data),
    .data_ack    (data_ack),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_mask    (mem_mask),
    .mem_wr_en   (mem_wr_en),
    .mem_req     (mem_req),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;
  own_t        own = OWN_NONE;
  own_t        last_win = OWN_I;
  int unsigned streak = 0;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_mask;
  logic        e_wr;
  logic        iack_seen = 1'b0;
  logic        dack_seen = 1'b0;
  logic        prev_req = 1'b0;
  int          cycle = 0;
  int unsigned lat_cnt = 0;
  int unsigned min_lat = 0;
  int unsigned max_lat = 0;
  own_t        dut_grants[$];
  int          rise_cycle[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic own_t pick(input logic ireq, input logic dreq);
    if (ireq && dreq) begin
`ifdef KRONOS_MEM_ARB_RR_EN
      return (last_win == OWN_I) ? OWN_D : OWN_I;
`else
      return (streak == STREAK_MAX) ? OWN_I : OWN_D;
`endif
    end
    if (dreq) return OWN_D;
    if (ireq) return OWN_I;
    return OWN_NONE;
  endfunction

  task automatic model_reset();
    own       = OWN_NONE;
    last_win  = OWN_I;
    streak    = 0;
    prev_req  = 1'b0;
    iack_seen = 1'b0;
    dack_seen = 1'b0;
  endtask

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic step();
    own_t win;
    #1;
    iack_seen = (own == OWN_I) && mem_ack;
    dack_seen = (own == OWN_D) && mem_ack;
    check("instr_ack", instr_ack, iack_seen);
    check("data_ack", data_ack, dack_seen);
    if (iack_seen) check("instr_data", instr_data, mem_rd_data);
    if (dack_seen) check("data_rd_data", data_rd_data, mem_rd_data);
    if (own == OWN_NONE) begin
      win = pick(instr_req, data_req);
      if (win == OWN_D) begin
        streak = instr_req ? ((streak < STREAK_SAT) ? streak + 1 : streak) : 0;
        e_addr = data_addr; e_wdata = data_wr_data; e_mask = data_mask; e_wr = data_wr_en;
      end else if (win == OWN_I) begin
        streak = 0;
        e_addr = instr_addr; e_wdata = 32'h0; e_mask = 4'hF; e_wr = 1'b0;
      end
      if (win != OWN_NONE) begin
        own      = win;
        last_win = win;
        lat_cnt  = $urandom_range(max_lat, min_lat);
      end
    end else if (mem_ack) begin
      own = OWN_NONE;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    check("mem_req", mem_req, own != OWN_NONE);
    if (own != OWN_NONE) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_wr_data", mem_wr_data, e_wdata);
      check("mem_mask", mem_mask, e_mask);
      check("mem_wr_en", mem_wr_en, e_wr);
    end
    if (mem_req && !prev_req) begin
      rise_cycle.push_back(cycle);
      dut_grants.push_back((mem_addr[31:28] == 4'h1) ? OWN_I : OWN_D);
    end
    prev_req = mem_req;
  endtask

  task automatic drive_masters(input int p_i, input int p_d, input int drop_pct);
    if (iack_seen || !instr_req) begin
      instr_req  = ($urandom_range(99) < p_i);
      instr_addr = {4'h1, 28'($urandom)};
    end else if ($urandom_range(99) < drop_pct) begin
      instr_req = 1'b0;
    end
    if (dack_seen || !data_req) begin
      data_req     = ($urandom_range(99) < p_d);
      data_addr    = {4'h2, 28'($urandom)};
      data_wr_data = $urandom;
      data_mask    = 4'($urandom);
      data_wr_en   = 1'($urandom);
    end else if ($urandom_range(99) < drop_pct) begin
      data_req = 1'b0;
    end
  endtask

  task automatic drive_mem(input int stray_pct);
    mem_ack = 1'b0;
    if (own != OWN_NONE) begin
      if (lat_cnt == 0) begin
        mem_ack     = 1'b1;
        mem_rd_data = $urandom;
      end else begin
        lat_cnt--;
      end
    end else if ($urandom_range(99) < stray_pct) begin
      mem_ack     = 1'b1;
      mem_rd_data = $urandom;
    end
  endtask

  task automatic do_reset();
    rstz      = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    mem_ack   = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst mem_req", mem_req, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wr_data", mem_wr_data, 32'h0);
    check("rst mem_mask", mem_mask, 4'h0);
    check("rst mem_wr_en", mem_wr_en, 1'b0);
    check("rst instr_ack", instr_ack, 1'b0);
    check("rst data_ack", data_ack, 1'b0);
    rstz    = 1'b1;
    mem_ack = 1'b0;
  endtask

  initial begin
    instr_addr = '0; data_addr = '0; data_wr_data = '0; mem_rd_data = '0;
    data_mask = '0; data_wr_en = 1'b0; instr_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
    do_reset();

    // Lone load, acked two cycles after mem_req rises.
    data_req = 1'b1; data_addr = 32'h100; data_wr_en = 1'b0; data_mask = 4'hF;
    data_wr_data = 32'h0;
    step();
    check("load mem_addr", mem_addr, 32'h100);
    check("load mem_wr_en", mem_wr_en, 1'b0);
    step();
    step();
    mem_ack = 1'b1; mem_rd_data = 32'hDEADBEEF;
    #1;
    check("load data_ack", data_ack, 1'b1);
    check("load rd_data", data_rd_data, 32'hDEADBEEF);
    step();
    mem_ack = 1'b0; data_req = 1'b0;
    step();

    // Lone store, acked in the first cycle of mem_req.
    data_req = 1'b1; data_addr = 32'h2000_0040; data_wr_en = 1'b1; data_mask = 4'b0011;
    data_wr_data = 32'h1234;
    step();
    check("store mem_wr_data", mem_wr_data, 32'h1234);
    check("store mem_mask", mem_mask, 4'b0011);
    check("store mem_wr_en", mem_wr_en, 1'b1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; data_req = 1'b0;
    step();

    // Stray ack while idle, then a normal grant.
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0; data_req = 1'b1; data_addr = 32'h2000_0080; data_wr_en = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; data_req = 1'b0;
    step();

    // Reset in the middle of a data transfer.
    data_req = 1'b1; data_addr = 32'h2000_0200; data_wr_en = 1'b0; data_mask = 4'hF;
    step();
    #2 rstz = 1'b0;
    #1;
    check("async mem_req", mem_req, 1'b0);
    check("async mem_addr", mem_addr, 32'h0);
    model_reset();
    data_req = 1'b0;
    @(negedge clk);
    rstz = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; data_req = 1'b1; data_addr = 32'h2000_0300;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; data_req = 1'b0;
    step();

    // Continuous contention with a one-cycle-latency memory.
    do_reset();
    dut_grants.delete();
    rise_cycle.delete();
    min_lat = 1; max_lat = 1;
    for (int c = 0; c < 200 && dut_grants.size() < 10; c++) begin
      drive_masters(100, 100, 0);
      drive_mem(0);
      step();
    end
    check("grant count", dut_grants.size(), 10);
    for (int k = 0; k < dut_grants.size() && k < 10; k++) begin
      own_t exp_g;
`ifdef KRONOS_MEM_ARB_RR_EN
      exp_g = (k % 2 == 0) ? OWN_D : OWN_I;
`else
      exp_g = (k % (STREAK_MAX + 1) == STREAK_MAX) ? OWN_I : OWN_D;
`endif
      check($sformatf("grant[%0d]", k), 32'(dut_grants[k]), 32'(exp_g));
      if (k > 0) check($sformatf("spacing[%0d]", k), rise_cycle[k] - rise_cycle[k-1], 3);
    end

    // Randomized traffic with stray acks and occasional early request drops.
    min_lat = 0; max_lat = 3;
    repeat (800) begin
      drive_masters(40, 50, 3);
      drive_mem(10);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
